// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: FSM states, S-box table, Rcon table
// and the NK/NR/NW derivations used by the key-schedule generator.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Round constants for word index i/NK; entry 0 is never used by the schedule.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr_of(input int key_bits);
    return nk_of(key_bits) + 6;
  endfunction

  function automatic int nw_of(input int key_bits);
    return 4 * (nr_of(key_bits) + 1);
  endfunction

endpackage

// File: rtl/key_schedule_gen_if.sv
// Control and round-key read bundle between the key-schedule generator and
// its users (cipher core, scan controller).
interface key_schedule_gen_if #(
  parameter int KEY_BITS = 128
);
  // start/clear/rd_en are single-cycle requests sampled on the rising edge;
  // there is no ready back-pressure. A read request always gets exactly one
  // response pulse (rd_key_valid or rd_err) in the following cycle.
  logic                start;
  logic [KEY_BITS-1:0] initial_key;
  logic                clear;
  logic                busy;
  logic                done;
  logic                key_ready;
  logic                rd_en;
  logic [3:0]          rd_round;
  logic                rd_key_valid;
  logic                rd_err;
  logic [127:0]        round_key;

  modport master (
    output start, initial_key, clear, rd_en, rd_round,
    input  busy, done, key_ready, rd_key_valid, rd_err, round_key
  );

  modport slave (
    input  start, initial_key, clear, rd_en, rd_round,
    output busy, done, key_ready, rd_key_valid, rd_err, round_key
  );
endinterface

// File: rtl/aes_sbox.sv
// Single AES S-box byte substitution, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = sbox(in_byte);
endmodule

// File: rtl/key_schedule_gen.sv
// AES-128/192/256 key expander: one schedule word per cycle into a
// zeroizable register store, then 1-cycle pipelined round-key reads.
module key_schedule_gen
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input logic               clk,
  input logic               reset,
  key_schedule_gen_if.slave bus
);

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);

  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [3:0] NR_W     = 4'(NR);
  localparam logic [2:0] MOD_LAST = 3'(NK - 1);

  ks_state_e state_q, state_d;

  logic [31:0]  w_q [NW];
  logic [31:0]  w_d [NW];
  logic [5:0]   cnt_q, cnt_d;
  logic [2:0]   mod_q, mod_d;
  logic [3:0]   rc_q, rc_d;
  logic         done_q, done_d;
  logic         rd_valid_q, rd_valid_d;
  logic         rd_err_q, rd_err_d;
  logic [127:0] round_key_q, round_key_d;

  logic busy, key_ready, gen_we, load;

  logic [5:0]  prev_idx, back_idx, rd_base;
  logic [31:0] w_prev, w_back, sub_in, sub_out, temp, new_word;
  logic        rd_ok;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; clear overrides everything, start is ignored in GEN
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (bus.start) state_d = ST_GEN;
        ST_GEN:           if (cnt_q == LAST_W) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q == ST_GEN);
    key_ready = (state_q == ST_DONE);
    gen_we    = (state_q == ST_GEN) && !bus.clear;
    load      = bus.start && !bus.clear && (state_q != ST_GEN);
  end

  // Next schedule word; mod_q tracks i mod NK, rc_q tracks i/NK
  always_comb begin
    prev_idx = cnt_q - 6'd1;
    back_idx = cnt_q - NK_W;
    w_prev   = w_q[prev_idx];
    w_back   = w_q[back_idx];
    sub_in   = (mod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  end

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    if (mod_q == 3'd0)                  temp = sub_out ^ {rcon(rc_q), 24'h0};
    else if (NK == 8 && mod_q == 3'd4)  temp = sub_out;
    else                                temp = w_prev;
    new_word = w_back ^ temp;
  end

  // Store and counter update
  always_comb begin
    w_d    = w_q;
    cnt_d  = cnt_q;
    mod_d  = mod_q;
    rc_d   = rc_q;
    done_d = 1'b0;
    if (bus.clear) begin
      for (int j = 0; j < NW; j++) w_d[j] = '0;
      cnt_d = '0;
      mod_d = '0;
      rc_d  = 4'd1;
    end else if (load) begin
      for (int j = 0; j < NK; j++) w_d[j] = bus.initial_key[KEY_BITS-1-32*j -: 32];
      cnt_d = NK_W;
      mod_d = '0;
      rc_d  = 4'd1;
    end else if (gen_we) begin
      w_d[cnt_q] = new_word;
      cnt_d      = cnt_q + 6'd1;
      if (mod_q == MOD_LAST) begin
        mod_d = '0;
        rc_d  = rc_q + 4'd1;
      end else begin
        mod_d = mod_q + 3'd1;
      end
      done_d = (cnt_q == LAST_W);
    end
  end

  // Reads see the schedule as it was before this edge, so a read coinciding
  // with a new start is still served from the old key.
  always_comb begin
    rd_ok       = bus.rd_en && key_ready && (bus.rd_round <= NR_W);
    rd_base     = {bus.rd_round, 2'b00};
    rd_valid_d  = rd_ok;
    rd_err_d    = bus.rd_en && !rd_ok;
    round_key_d = round_key_q;
    if (rd_ok) begin
      round_key_d = {w_q[rd_base], w_q[rd_base + 6'd1],
                     w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end else if (bus.rd_en) begin
      round_key_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NW; j++) w_q[j] <= '0;
      cnt_q       <= '0;
      mod_q       <= '0;
      rc_q        <= 4'd1;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      round_key_q <= '0;
    end else begin
      for (int j = 0; j < NW; j++) w_q[j] <= w_d[j];
      cnt_q       <= cnt_d;
      mod_q       <= mod_d;
      rc_q        <= rc_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      round_key_q <= round_key_d;
    end
  end

  assign bus.busy         = busy;
  assign bus.key_ready    = key_ready;
  assign bus.done         = done_q;
  assign bus.rd_key_valid = rd_valid_q;
  assign bus.rd_err       = rd_err_q;
  assign bus.round_key    = round_key_q;

endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed bench for key_schedule_gen: FIPS-197 vectors for 128/192/256-bit
// keys, read rejection, start/read overlap, clear and reset aborts.
module tb_key_schedule_gen;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  localparam logic [255:0] K128_FIPS = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K_ZERO    = 256'h0;
  localparam logic [255:0] K192      = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256      = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] R0_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R1_ZERO  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] R10_ZERO = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] R0_192   = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R1_192   = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] R12_192  = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R0_256   = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R1_256   = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R14_256  = 128'hfe4890d1e6188d0b046df344706c631e;

  key_schedule_gen_if #(.KEY_BITS(128)) if128 ();
  key_schedule_gen_if #(.KEY_BITS(192)) if192 ();
  key_schedule_gen_if #(.KEY_BITS(256)) if256 ();

  key_schedule_gen #(.KEY_BITS(128)) dut128 (.clk(clk), .reset(reset), .bus(if128));
  key_schedule_gen #(.KEY_BITS(192)) dut192 (.clk(clk), .reset(reset), .bus(if192));
  key_schedule_gen #(.KEY_BITS(256)) dut256 (.clk(clk), .reset(reset), .bus(if256));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input int sel, input logic st, input logic [255:0] key,
                            input logic clr, input logic re, input logic [3:0] rr);
    case (sel)
      0: begin
        if128.start = st; if128.initial_key = key[127:0]; if128.clear = clr;
        if128.rd_en = re; if128.rd_round = rr;
      end
      1: begin
        if192.start = st; if192.initial_key = key[191:0]; if192.clear = clr;
        if192.rd_en = re; if192.rd_round = rr;
      end
      default: begin
        if256.start = st; if256.initial_key = key; if256.clear = clr;
        if256.rd_en = re; if256.rd_round = rr;
      end
    endcase
  endtask

  task automatic get_status(input int sel, output logic busy, output logic done,
                            output logic ready, output logic valid, output logic err,
                            output logic [127:0] key);
    case (sel)
      0: begin
        busy = if128.busy; done = if128.done; ready = if128.key_ready;
        valid = if128.rd_key_valid; err = if128.rd_err; key = if128.round_key;
      end
      1: begin
        busy = if192.busy; done = if192.done; ready = if192.key_ready;
        valid = if192.rd_key_valid; err = if192.rd_err; key = if192.round_key;
      end
      default: begin
        busy = if256.busy; done = if256.done; ready = if256.key_ready;
        valid = if256.rd_key_valid; err = if256.rd_err; key = if256.round_key;
      end
    endcase
  endtask

  task automatic do_start(input int sel, input logic [255:0] key);
    @(negedge clk);
    set_inputs(sel, 1'b1, key, 1'b0, 1'b0, 4'd0);
    @(posedge clk); #1;
    set_inputs(sel, 1'b0, key, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_clear(input int sel);
    @(negedge clk);
    set_inputs(sel, 1'b0, K_ZERO, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    set_inputs(sel, 1'b0, K_ZERO, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_read(input int sel, input logic [3:0] r, output logic valid,
                         output logic err, output logic [127:0] key);
    logic b, d, rdy;
    @(negedge clk);
    set_inputs(sel, 1'b0, K_ZERO, 1'b0, 1'b1, r);
    @(posedge clk); #1;
    get_status(sel, b, d, rdy, valid, err, key);
    set_inputs(sel, 1'b0, K_ZERO, 1'b0, 1'b0, 4'd0);
  endtask

  // Edges counted until done is seen; -1 if it never arrives within budget.
  task automatic wait_done(input int sel, output int n);
    logic b, d, rdy, v, e;
    logic [127:0] k;
    n = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      get_status(sel, b, d, rdy, v, e, k);
      if (d) begin
        n = c;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic b, d, rdy, v, e;
    logic [127:0] k;
    for (int s = 0; s < 3; s++) begin
      get_status(s, b, d, rdy, v, e, k);
      checks++;
      if ({b, d, rdy, v, e} !== 5'b0 || k !== 128'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: busy/done/ready/valid/err=%b%b%b%b%b key=%h required 00000 key=0",
                 s, b, d, rdy, v, e, k);
      end
    end
    do_read(0, 4'd0, v, e, k);
    checks++;
    if (v !== 1'b0 || e !== 1'b1 || k !== 128'h0) begin
      errors++;
      $display("FAIL reset_read_rejected: valid=%b err=%b key=%h required valid=0 err=1 key=0", v, e, k);
    end
  endtask

  task automatic test_aes128_fips();
    logic b, d, rdy, v, e;
    logic [127:0] k;
    int n;
    do_start(0, K128_FIPS);
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (b !== 1'b1 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL a128_busy_after_start: busy=%b ready=%b required busy=1 ready=0", b, rdy);
    end
    wait_done(0, n);
    checks++;
    if (n !== 40) begin
      errors++;
      $display("FAIL a128_latency: got %0d edges, required 40", n);
    end
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (rdy !== 1'b1 || b !== 1'b0) begin
      errors++;
      $display("FAIL a128_ready_at_done: ready=%b busy=%b required ready=1 busy=0", rdy, b);
    end
    @(posedge clk); #1;
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (d !== 1'b0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL a128_done_pulse: done=%b ready=%b required done=0 ready=1", d, rdy);
    end
    do_read(0, 4'd10, v, e, k);
    checks++;
    if (v !== 1'b1 || e !== 1'b0 || k !== R10_FIPS) begin
      errors++;
      $display("FAIL a128_round10: valid=%b err=%b key=%h required 1 0 %h", v, e, k, R10_FIPS);
    end
    do_read(0, 4'd0, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R0_FIPS) begin
      errors++;
      $display("FAIL a128_round0: valid=%b key=%h required 1 %h", v, k, R0_FIPS);
    end
    // No request: valid drops, key holds
    @(posedge clk); #1;
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (v !== 1'b0 || e !== 1'b0 || k !== R0_FIPS) begin
      errors++;
      $display("FAIL a128_key_hold: valid=%b err=%b key=%h required 0 0 %h", v, e, k, R0_FIPS);
    end
  endtask

  task automatic test_back_to_back();
    logic b, d, rdy, v, e;
    logic [127:0] k;
    @(negedge clk);
    set_inputs(0, 1'b0, K_ZERO, 1'b0, 1'b1, 4'd1);
    @(posedge clk); #1;
    set_inputs(0, 1'b0, K_ZERO, 1'b0, 1'b1, 4'd10);
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R1_FIPS) begin
      errors++;
      $display("FAIL b2b_first: valid=%b key=%h required 1 %h", v, k, R1_FIPS);
    end
    @(posedge clk); #1;
    set_inputs(0, 1'b0, K_ZERO, 1'b0, 1'b0, 4'd0);
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R10_FIPS) begin
      errors++;
      $display("FAIL b2b_second: valid=%b key=%h required 1 %h", v, k, R10_FIPS);
    end
  endtask

  task automatic test_read_with_start();
    logic b, d, rdy, v, e;
    logic [127:0] k;
    int n;
    @(negedge clk);
    set_inputs(0, 1'b1, K_ZERO, 1'b0, 1'b1, 4'd10);
    @(posedge clk); #1;
    set_inputs(0, 1'b0, K_ZERO, 1'b0, 1'b0, 4'd0);
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R10_FIPS || rdy !== 1'b0 || b !== 1'b1) begin
      errors++;
      $display("FAIL read_with_start: valid=%b key=%h ready=%b busy=%b required 1 %h 0 1",
               v, k, rdy, b, R10_FIPS);
    end
    wait_done(0, n);
    checks++;
    if (n !== 40) begin
      errors++;
      $display("FAIL zero_latency: got %0d edges, required 40", n);
    end
    do_read(0, 4'd1, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R1_ZERO) begin
      errors++;
      $display("FAIL zero_round1: valid=%b key=%h required 1 %h", v, k, R1_ZERO);
    end
    do_read(0, 4'd10, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R10_ZERO) begin
      errors++;
      $display("FAIL zero_round10: valid=%b key=%h required 1 %h", v, k, R10_ZERO);
    end
  endtask

  task automatic test_rd_err();
    logic b, d, rdy, v, e;
    logic [127:0] k;
    int n, m;
    do_read(0, 4'd11, v, e, k);
    checks++;
    if (v !== 1'b0 || e !== 1'b1 || k !== 128'h0) begin
      errors++;
      $display("FAIL err_round11: valid=%b err=%b key=%h required 0 1 0", v, e, k);
    end
    @(posedge clk); #1;
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width: err=%b required 0", e);
    end
    do_start(0, K128_FIPS);
    n = 0;
    do_read(0, 4'd0, v, e, k);
    n++;
    checks++;
    if (v !== 1'b0 || e !== 1'b1 || k !== 128'h0) begin
      errors++;
      $display("FAIL err_while_busy: valid=%b err=%b key=%h required 0 1 0", v, e, k);
    end
    // A second start during GEN must not restart or reload
    @(negedge clk);
    set_inputs(0, 1'b1, K_ZERO, 1'b0, 1'b0, 4'd0);
    @(posedge clk); #1;
    set_inputs(0, 1'b0, K_ZERO, 1'b0, 1'b0, 4'd0);
    n++;
    wait_done(0, m);
    checks++;
    if (m < 0 || n + m !== 40) begin
      errors++;
      $display("FAIL start_ignored_latency: got %0d edges, required 40", n + m);
    end
    do_read(0, 4'd10, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R10_FIPS) begin
      errors++;
      $display("FAIL start_ignored_key: valid=%b key=%h required 1 %h", v, k, R10_FIPS);
    end
  endtask

  task automatic test_clear_abort();
    logic b, d, rdy, v, e;
    logic [127:0] k;
    logic saw_done;
    int n;
    do_start(0, K128_FIPS);
    repeat (19) @(posedge clk);
    #1;
    do_clear(0);
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (b !== 1'b0 || rdy !== 1'b0 || d !== 1'b0) begin
      errors++;
      $display("FAIL clear_abort_state: busy=%b ready=%b done=%b required 0 0 0", b, rdy, d);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      get_status(0, b, d, rdy, v, e, k);
      if (d || rdy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_done: done/ready seen=%b required 0", saw_done);
    end
    do_read(0, 4'd0, v, e, k);
    checks++;
    if (v !== 1'b0 || e !== 1'b1 || k !== 128'h0) begin
      errors++;
      $display("FAIL clear_read_rejected: valid=%b err=%b key=%h required 0 1 0", v, e, k);
    end
    // Reset in the middle of a fresh expansion
    do_start(0, K128_FIPS);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    get_status(0, b, d, rdy, v, e, k);
    checks++;
    if (b !== 1'b0 || rdy !== 1'b0 || d !== 1'b0 || k !== 128'h0) begin
      errors++;
      $display("FAIL reset_abort_state: busy=%b ready=%b done=%b key=%h required 0 0 0 0", b, rdy, d, k);
    end
    do_start(0, K_ZERO);
    wait_done(0, n);
    checks++;
    if (n !== 40) begin
      errors++;
      $display("FAIL restart_latency: got %0d edges, required 40", n);
    end
    do_read(0, 4'd10, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R10_ZERO) begin
      errors++;
      $display("FAIL restart_round10: valid=%b key=%h required 1 %h", v, k, R10_ZERO);
    end
  endtask

  task automatic test_aes192();
    logic v, e;
    logic [127:0] k;
    int n;
    do_start(1, K192);
    wait_done(1, n);
    checks++;
    if (n !== 46) begin
      errors++;
      $display("FAIL a192_latency: got %0d edges, required 46", n);
    end
    do_read(1, 4'd0, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R0_192) begin
      errors++;
      $display("FAIL a192_round0: valid=%b key=%h required 1 %h", v, k, R0_192);
    end
    do_read(1, 4'd1, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R1_192) begin
      errors++;
      $display("FAIL a192_round1: valid=%b key=%h required 1 %h", v, k, R1_192);
    end
    do_read(1, 4'd12, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R12_192) begin
      errors++;
      $display("FAIL a192_round12: valid=%b key=%h required 1 %h", v, k, R12_192);
    end
    do_read(1, 4'd13, v, e, k);
    checks++;
    if (v !== 1'b0 || e !== 1'b1 || k !== 128'h0) begin
      errors++;
      $display("FAIL a192_round13_err: valid=%b err=%b key=%h required 0 1 0", v, e, k);
    end
  endtask

  task automatic test_aes256();
    logic v, e;
    logic [127:0] k;
    int n;
    do_start(2, K256);
    wait_done(2, n);
    checks++;
    if (n !== 52) begin
      errors++;
      $display("FAIL a256_latency: got %0d edges, required 52", n);
    end
    do_read(2, 4'd0, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R0_256) begin
      errors++;
      $display("FAIL a256_round0: valid=%b key=%h required 1 %h", v, k, R0_256);
    end
    do_read(2, 4'd1, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R1_256) begin
      errors++;
      $display("FAIL a256_round1: valid=%b key=%h required 1 %h", v, k, R1_256);
    end
    do_read(2, 4'd14, v, e, k);
    checks++;
    if (v !== 1'b1 || k !== R14_256) begin
      errors++;
      $display("FAIL a256_round14: valid=%b key=%h required 1 %h", v, k, R14_256);
    end
    do_read(2, 4'd15, v, e, k);
    checks++;
    if (v !== 1'b0 || e !== 1'b1 || k !== 128'h0) begin
      errors++;
      $display("FAIL a256_round15_err: valid=%b err=%b key=%h required 0 1 0", v, e, k);
    end
    do_clear(2);
    do_read(2, 4'd14, v, e, k);
    checks++;
    if (v !== 1'b0 || e !== 1'b1) begin
      errors++;
      $display("FAIL a256_clear_from_done: valid=%b err=%b required 0 1", v, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int s = 0; s < 3; s++) set_inputs(s, 1'b0, K_ZERO, 1'b0, 1'b0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_aes128_fips();
    test_back_to_back();
    test_read_with_start();
    test_rd_err();
    test_clear_abort();
    test_aes192();
    test_aes256();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
